// File: rtl/spi_pkg.sv
// Shared SPI definitions for the byte responder and the master sequencer.
// Provides the state enum, byte width and default idle fill byte.
package spi_pkg;

    localparam int SPI_BYTE_W = 8;

    localparam logic [SPI_BYTE_W-1:0] SPI_IDLE_FILL = 8'h00;

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin, plus rise/fall pulses.
// Ports: clk, rst_n, i_async (raw pin), o_sync (synced level),
//        o_rise / o_fall (one-cycle pulses on synced edges).
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {STAGES{RST_VAL}};
            r_prev <= RST_VAL;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_sync = r_sync[STAGES-1];
    assign o_rise = o_sync & ~r_prev;
    assign o_fall = ~o_sync & r_prev;

endmodule

// File: rtl/spi_slave_byte.sv
// SPI Mode 0 MSB-first byte responder, fully in the clk domain.
// Ports: sclk/cs_n/mosi (async pins in), miso/miso_oe (pad out),
//        rx_data/rx_valid (received byte strobe), tx_data/tx_load/tx_ready
//        (response holding register), underrun, busy.
module spi_slave_byte
    import spi_pkg::*;
#(
    parameter int                    SYNC_STAGES = 2,
    parameter logic [SPI_BYTE_W-1:0] IDLE_FILL   = SPI_IDLE_FILL
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    output logic [SPI_BYTE_W-1:0] rx_data,
    output logic                  rx_valid,
    input  logic [SPI_BYTE_W-1:0] tx_data,
    input  logic                  tx_load,
    output logic                  tx_ready,
    output logic                  underrun,
    output logic                  busy
);

    logic w_sclk_s, w_sclk_rise, w_sclk_fall;
    logic w_cs_s, w_cs_rise, w_cs_fall;
    logic w_mosi_s, w_mosi_rise, w_mosi_fall;
    logic w_unused;

    // All three pins share the same depth so mosi lines up with sclk edges.
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_async(sclk),
        .o_sync (w_sclk_s),
        .o_rise (w_sclk_rise),
        .o_fall (w_sclk_fall)
    );

    // cs_n resets high so leaving reset never looks like a select.
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_async(cs_n),
        .o_sync (w_cs_s),
        .o_rise (w_cs_rise),
        .o_fall (w_cs_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_async(mosi),
        .o_sync (w_mosi_s),
        .o_rise (w_mosi_rise),
        .o_fall (w_mosi_fall)
    );

    assign w_unused = ^{w_sclk_s, w_cs_s, w_mosi_rise, w_mosi_fall};

    spi_state_e            r_state;
    logic [2:0]            r_cnt;
    logic [SPI_BYTE_W-2:0] r_shift_rx;
    logic [SPI_BYTE_W-1:0] r_shift_tx;
    logic [SPI_BYTE_W-1:0] r_rx_data;
    logic                  r_rx_valid;
    logic [SPI_BYTE_W-1:0] r_hold;
    logic                  r_hold_full;
    logic                  r_underrun;

    logic w_load_ok;
    logic w_reload;
    logic w_active;

    assign w_active  = (r_state == ST_ACTIVE);
    assign w_load_ok = tx_load & ~r_hold_full;

    // Reload at select, and at each byte-boundary falling edge.
    // A cs_n edge in the same cycle overrides any sclk edge.
    assign w_reload = (!w_active && w_cs_fall) ||
                      (w_active && !w_cs_rise && w_sclk_fall && r_cnt == 3'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 3'd0;
            r_shift_rx  <= '0;
            r_shift_tx  <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_underrun <= 1'b0;

            // Load and reload-consume are disjoint on r_hold_full.
            if (w_load_ok) begin
                r_hold      <= tx_data;
                r_hold_full <= 1'b1;
            end

            if (w_reload) begin
                if (r_hold_full) begin
                    r_shift_tx  <= r_hold;
                    r_hold_full <= 1'b0;
                end else begin
                    r_shift_tx <= IDLE_FILL;
                    r_underrun <= 1'b1;
                end
            end

            unique case (r_state)
                ST_IDLE: begin
                    r_cnt <= 3'd0;
                    if (w_cs_fall)
                        r_state <= ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (w_cs_rise) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= 3'd0;
                    end else begin
                        if (w_sclk_rise) begin
                            r_shift_rx <= {r_shift_rx[SPI_BYTE_W-3:0], w_mosi_s};
                            r_cnt      <= r_cnt + 3'd1;
                            if (r_cnt == 3'd7) begin
                                r_rx_data  <= {r_shift_rx, w_mosi_s};
                                r_rx_valid <= 1'b1;
                            end
                        end
                        if (w_sclk_fall && r_cnt != 3'd0)
                            r_shift_tx <= {r_shift_tx[SPI_BYTE_W-2:0], 1'b0};
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign miso     = w_active & r_shift_tx[SPI_BYTE_W-1];
    assign miso_oe  = w_active;
    assign busy     = w_active;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign tx_ready = ~r_hold_full;
    assign underrun = r_underrun;

endmodule

// File: tb/tb_spi_slave_byte.sv
// Bench for spi_slave_byte: directed Mode 0 transactions then random ones,
// checked against a holding-register/response model kept here.
module tb_spi_slave_byte;
    import spi_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk = 1'b0;
    logic       cs_n = 1'b1;
    logic       mosi = 1'b0;
    logic       miso, miso_oe, rx_valid, tx_ready, underrun, busy;
    logic [7:0] rx_data;
    logic [7:0] tx_data = 8'h00;
    logic       tx_load = 1'b0;

    always #5 clk = ~clk;

    spi_slave_byte dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sclk    (sclk),
        .cs_n    (cs_n),
        .mosi    (mosi),
        .miso    (miso),
        .miso_oe (miso_oe),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .tx_data (tx_data),
        .tx_load (tx_load),
        .tx_ready(tx_ready),
        .underrun(underrun),
        .busy    (busy)
    );

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] rx_q[$];
    int         und_cnt = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid) rx_q.push_back(rx_data);
            if (underrun) und_cnt++;
        end
    end

    logic [7:0] m_tx[4];
    logic       mdl_full = 1'b0;
    logic [7:0] mdl_hold = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic void model_load(input logic [7:0] b);
        if (!mdl_full) begin
            mdl_full = 1'b1;
            mdl_hold = b;
        end
    endfunction

    task automatic do_load(input logic [7:0] b);
        tx_data = b;
        tx_load = 1'b1;
        tick(1);
        tx_load = 1'b0;
        model_load(b);
        check("tx_ready_after_load", tx_ready, 0);
    endtask

    // One select period of nbytes; last byte may be cut to last_bits.
    // inj_at>0 raises tx_load in the cycle of that byte-boundary reload.
    task automatic run_txn(input int nbytes, input int last_bits,
                           input int inj_at, input logic [7:0] inj_data);
        int         ub, qb, nb, exp_und, n_full;
        logic [7:0] exp_resp[4];
        logic [7:0] got;
        ub      = und_cnt;
        qb      = rx_q.size();
        exp_und = 0;
        cs_n    = 1'b0;
        tick(8);
        check("busy_active", busy, 1);
        check("miso_oe_active", miso_oe, 1);
        for (int b = 0; b < nbytes; b++) begin
            if (mdl_full) begin
                exp_resp[b] = mdl_hold;
                mdl_full    = 1'b0;
            end else begin
                exp_resp[b] = SPI_IDLE_FILL;
                exp_und++;
            end
            if (b == 0)
                check("tx_ready_after_start", tx_ready, 1);
            if (inj_at == b && b > 0)
                model_load(inj_data);
            nb  = (b == nbytes - 1) ? last_bits : 8;
            got = 8'h00;
            for (int i = 0; i < nb; i++) begin
                mosi = m_tx[b][7-i];
                if (inj_at == b && b > 0 && i == 0) begin
                    tick(2);
                    tx_data = inj_data;
                    tx_load = 1'b1;
                    tick(1);
                    tx_load = 1'b0;
                    tick(1);
                end else begin
                    tick(4);
                end
                got[7-i] = miso;
                sclk     = 1'b1;
                tick(4);
                if (!(b == nbytes - 1 && i == nb - 1))
                    sclk = 1'b0;
            end
            if (nb == 8)
                check("miso_byte", got, exp_resp[b]);
        end
        // Final sclk fall coincides with deselect, so no trailing reload.
        sclk = 1'b0;
        cs_n = 1'b1;
        tick(10);
        n_full = (last_bits == 8) ? nbytes : nbytes - 1;
        check("rx_count", rx_q.size() - qb, n_full);
        for (int b = 0; b < n_full; b++) begin
            if (qb + b < rx_q.size())
                check("rx_byte", rx_q[qb+b], m_tx[b]);
        end
        check("underrun_count", und_cnt - ub, exp_und);
        check("busy_idle", busy, 0);
        check("miso_oe_idle", miso_oe, 0);
        check("miso_idle", miso, 0);
        check("tx_ready_idle", tx_ready, !mdl_full);
    endtask

    initial begin
        int nbr;
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(2);
        check("rst_miso", miso, 0);
        check("rst_miso_oe", miso_oe, 0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_underrun", underrun, 0);
        check("rst_busy", busy, 0);

        m_tx[0] = 8'h5A;
        do_load(8'hA5);
        run_txn(1, 8, -1, 8'h00);

        m_tx[0] = 8'hA5;
        m_tx[1] = 8'h5A;
        m_tx[2] = 8'h3C;
        m_tx[3] = 8'hC3;
        do_load(8'hA5);
        run_txn(4, 8, -1, 8'h00);

        m_tx[0] = 8'hF0;
        run_txn(1, 5, -1, 8'h00);
        m_tx[0] = 8'h3C;
        run_txn(1, 8, -1, 8'h00);

        m_tx[0] = 8'h96;
        do_load(8'h22);
        do_load(8'h11);
        run_txn(1, 8, -1, 8'h00);

        m_tx[0] = 8'h01;
        m_tx[1] = 8'h02;
        m_tx[2] = 8'h03;
        run_txn(3, 8, 1, 8'h77);

        do_load(8'h99);
        cs_n = 1'b0;
        tick(8);
        do_load(8'h44);
        for (int i = 0; i < 4; i++) begin
            mosi = i[0];
            tick(4);
            sclk = 1'b1;
            tick(4);
            sclk = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check("mid_rst_miso", miso, 0);
        check("mid_rst_miso_oe", miso_oe, 0);
        check("mid_rst_rx_data", rx_data, 8'h00);
        check("mid_rst_rx_valid", rx_valid, 0);
        check("mid_rst_tx_ready", tx_ready, 1);
        check("mid_rst_underrun", underrun, 0);
        check("mid_rst_busy", busy, 0);
        mdl_full = 1'b0;
        tick(2);
        sclk = 1'b0;
        cs_n = 1'b1;
        mosi = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(4);

        m_tx[0] = 8'hC7;
        do_load(8'h6B);
        run_txn(1, 8, -1, 8'h00);

        for (int it = 0; it < 8; it++) begin
            nbr = $urandom_range(1, 3);
            for (int b = 0; b < 4; b++)
                m_tx[b] = 8'($urandom);
            if ($urandom_range(0, 1) == 1)
                do_load(8'($urandom));
            if ($urandom_range(0, 1) == 1)
                do_load(8'($urandom));
            run_txn(nbr, 8, -1, 8'h00);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
